// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the clock period monitor:
//   - mon_state_e : monitor FSM state encoding
//   - tol_lo/tol_hi : constant functions giving the inclusive bounds of the
//                     accepted half-period window around the expected value
// -----------------------------------------------------------------------------
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // waiting for a reference edge
        ST_MEASURE = 2'd1,   // capturing, not yet locked
        ST_LOCKED  = 2'd2    // enough consecutive in-tolerance captures
    } mon_state_e;

    // Lower bound clamps at zero so a tolerance wider than the expected value
    // does not wrap around to a huge unsigned number.
    function automatic longint unsigned tol_lo(input longint unsigned exp_half,
                                               input longint unsigned tol);
        return (tol >= exp_half) ? 64'd0 : (exp_half - tol);
    endfunction

    function automatic longint unsigned tol_hi(input longint unsigned exp_half,
                                               input longint unsigned tol);
        return exp_half + tol;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk_in domain through a SYNC_STAGES
// flop chain, then compares it with a history flop to flag edges.
//
// Ports:
//   clk_in  in  : sampling clock
//   rst_n   in  : synchronous active-low reset, clears every flop
//   d       in  : asynchronous input level
//   rise    out : high for one cycle when the synchronised level goes 0->1
//   fall    out : high for one cycle when the synchronised level goes 1->0
//   level   out : synchronised level
//
// rise/fall are decoded from flops only, so they are glitch-free and valid one
// cycle after the change reaches the last synchroniser stage.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  level & ~hist_q;
    assign fall  = ~level &  hist_q;

endmodule

// File: rtl/clock_period_monitor.sv
// -----------------------------------------------------------------------------
// clock_period_monitor
// Synchronises a slow toggling clock into clk_in, emits one-cycle rise/fall
// ticks, measures every half-period in clk_in cycles and reports lock once the
// measurement has stayed inside EXP_HALF +/- TOL for LOCK_COUNT consecutive
// half-periods. A missing edge for TIMEOUT cycles drops back to IDLE.
//
// Ports:
//   clk_in       in          : system clock
//   rst_n        in          : synchronous active-low reset
//   slow_in      in          : asynchronous toggling input (divided clock)
//   tick_rise    out         : one-cycle pulse per synchronised rising edge
//   tick_fall    out         : one-cycle pulse per synchronised falling edge
//   half_period  out [CNT_W] : last measured half-period in clk_in cycles
//   period_valid out         : one-cycle strobe when half_period updates
//   locked       out         : level, in tolerance for LOCK_COUNT half-periods
//   timeout      out         : level, no edge for TIMEOUT cycles
// -----------------------------------------------------------------------------
module clock_period_monitor #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned EXP_HALF    = 50_000_000,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 2 * EXP_HALF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    import clk_mon_pkg::*;

    localparam int unsigned      MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_COUNT);
    // Bounds are one bit wider than the counter so cnt+1 never wraps when the
    // counter sits at its saturation value.
    localparam logic [CNT_W:0] BOUND_LO = (CNT_W+1)'(tol_lo(64'(EXP_HALF), 64'(TOL)));
    localparam logic [CNT_W:0] BOUND_HI = (CNT_W+1)'(tol_hi(64'(EXP_HALF), 64'(TOL)));

    logic               rise;
    logic               fall;
    logic               level;
    logic               edge_seen;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W:0]     cnt_p1;
    logic               in_tol;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_next;
    mon_state_e         state;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (slow_in),
        .rise   (rise),
        .fall   (fall),
        .level  (level)
    );

    assign edge_seen  = rise | fall;
    // Length of the half-period ending at this edge: edges N cycles apart
    // leave cnt at N-1.
    assign cnt_p1     = {1'b0, cnt} + (CNT_W+1)'(1);
    assign in_tol     = (cnt_p1 >= BOUND_LO) && (cnt_p1 <= BOUND_HI);
    assign match_next = match_cnt + MATCH_W'(1);

    // Cycles since the last edge, saturating so a dead input cannot wrap it.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_seen) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Ticks, capture, match counting and lock state share one registered
    // block so all of them change on the same clk_in edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            match_cnt    <= '0;
            tick_rise    <= 1'b0;
            tick_fall    <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // Direction comes from the synchronised level at the edge.
            tick_rise    <= edge_seen &  level;
            tick_fall    <= edge_seen & ~level;
            period_valid <= 1'b0;

            if (edge_seen) begin
                // An edge always wins over a coincident timeout.
                timeout <= 1'b0;
                // NOTE: two state bits encode three states, so the default
                // arm keeps the unused code from becoming a trap state.
                case (state)
                    ST_IDLE: begin
                        state     <= ST_MEASURE;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                    ST_MEASURE: begin
                        half_period  <= cnt_p1[CNT_W-1:0];
                        period_valid <= 1'b1;
                        if (in_tol) begin
                            match_cnt <= match_next;
                            if (match_next == LOCK_MATCH) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        half_period  <= cnt_p1[CNT_W-1:0];
                        period_valid <= 1'b1;
                        if (!in_tol) begin
                            state     <= ST_MEASURE;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end else if (cnt == TIMEOUT_C) begin
                state     <= ST_IDLE;
                match_cnt <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_period_monitor
// Directed bench for clock_period_monitor with EXP_HALF=10, TOL=1,
// LOCK_COUNT=3, TIMEOUT=40. Inputs change 1 time unit after a rising clk_in
// edge; outputs are read at that same point, away from the active edge.
// Flag vectors are packed as {tick_rise, tick_fall, period_valid, locked,
// timeout}.
// -----------------------------------------------------------------------------
module tb_clock_period_monitor;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned EXP_HALF    = 10;
    localparam int unsigned TOL         = 1;
    localparam int unsigned LOCK_COUNT  = 3;
    localparam int unsigned TIMEOUT     = 40;
    localparam int unsigned SYNC_STAGES = 2;

    // Half-period sequence for the tolerance scenario and the lock state
    // expected after each capture.
    localparam int TOL_GAPS [14] = '{11, 9, 11, 12, 10, 10, 10, 8, 10, 10, 12, 10, 10, 10};
    localparam bit TOL_LOCK [14] = '{ 0, 0,  1,  0,  0,  0,  1, 0,  0,  0,  0,  0,  0,  1};

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             slow_in;
    logic             tick_rise;
    logic             tick_fall;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic [4:0]       flags;
    logic [4:0]       exp_flags;

    int errors = 0;
    int checks = 0;

    assign flags = {tick_rise, tick_fall, period_valid, locked, timeout};

    clock_period_monitor #(
        .CNT_W       (CNT_W),
        .EXP_HALF    (EXP_HALF),
        .TOL         (TOL),
        .LOCK_COUNT  (LOCK_COUNT),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .slow_in      (slow_in),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Toggle slow_in and advance to the cycle where its tick is visible.
    task automatic send_edge();
        slow_in = ~slow_in;
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        slow_in = 1'b0;
        cyc();
        rst_n   = 1'b1;
    endtask

    // Reference edge plus three 10-cycle half-periods; ends one cycle after
    // the locking tick, with slow_in back at 0.
    task automatic lock_up();
        send_edge();
        cyc();
        repeat (3) begin
            idle(6);
            send_edge();
            cyc();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        slow_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slow_in = ~slow_in;
            cyc();
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold[%0d] flags: got %b want %b", i, flags, 5'b00000);
            end
            checks++;
            if (half_period !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d] half_period: got %0d want 0", i, half_period);
            end
        end
        slow_in = 1'b0;
        cyc();
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release flags: got %b want %b", flags, 5'b00000);
        end
        slow_in = 1'b1;
        idle(2);
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL reset_tick_early flags: got %b want %b", flags, 5'b00000);
        end
        cyc();
        checks++;
        if (flags !== 5'b10000) begin
            errors++;
            $display("FAIL reset_first_tick flags: got %b want %b", flags, 5'b10000);
        end
    endtask

    task automatic test_lock();
        do_reset();
        idle(3);
        send_edge();
        checks++;
        if (flags !== 5'b10000 || half_period !== '0) begin
            errors++;
            $display("FAIL lock_ref: flags %b half %0d want flags 10000 half 0", flags, half_period);
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            idle(6);
            send_edge();
            exp_flags = {slow_in, ~slow_in, 1'b1, (i >= 2), 1'b0};
            checks++;
            if (flags !== exp_flags) begin
                errors++;
                $display("FAIL lock_edge[%0d] flags: got %b want %b", i, flags, exp_flags);
            end
            checks++;
            if (half_period !== 32'd10) begin
                errors++;
                $display("FAIL lock_edge[%0d] half_period: got %0d want 10", i, half_period);
            end
            cyc();
            exp_flags = {3'b000, (i >= 2), 1'b0};
            checks++;
            if (flags !== exp_flags) begin
                errors++;
                $display("FAIL lock_pulse[%0d] flags: got %b want %b", i, flags, exp_flags);
            end
        end
    endtask

    task automatic test_tolerance();
        do_reset();
        send_edge();
        cyc();
        for (int i = 0; i < 14; i++) begin
            idle(TOL_GAPS[i] - 4);
            send_edge();
            exp_flags = {slow_in, ~slow_in, 1'b1, TOL_LOCK[i], 1'b0};
            checks++;
            if (flags !== exp_flags) begin
                errors++;
                $display("FAIL tol[%0d] flags: got %b want %b", i, flags, exp_flags);
            end
            checks++;
            if (half_period !== 32'(TOL_GAPS[i])) begin
                errors++;
                $display("FAIL tol[%0d] half_period: got %0d want %0d", i, half_period, TOL_GAPS[i]);
            end
            cyc();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        lock_up();
        checks++;
        if (flags !== 5'b00010) begin
            errors++;
            $display("FAIL timeout_locked flags: got %b want %b", flags, 5'b00010);
        end
        // cnt is 1 here; 39 more cycles bring it to TIMEOUT.
        idle(39);
        checks++;
        if (flags !== 5'b00010) begin
            errors++;
            $display("FAIL timeout_early flags: got %b want %b", flags, 5'b00010);
        end
        cyc();
        checks++;
        if (flags !== 5'b00001 || half_period !== 32'd10) begin
            errors++;
            $display("FAIL timeout_assert: flags %b half %0d want flags 00001 half 10", flags, half_period);
        end
        idle(5);
        checks++;
        if (flags !== 5'b00001) begin
            errors++;
            $display("FAIL timeout_hold flags: got %b want %b", flags, 5'b00001);
        end
        send_edge();
        exp_flags = {slow_in, ~slow_in, 3'b000};
        checks++;
        if (flags !== exp_flags || half_period !== 32'd10) begin
            errors++;
            $display("FAIL timeout_clear: flags %b half %0d want flags %b half 10", flags, half_period, exp_flags);
        end
        // Next edge lands exactly when cnt reaches TIMEOUT: captured, no timeout.
        cyc();
        idle(37);
        send_edge();
        exp_flags = {slow_in, ~slow_in, 3'b100};
        checks++;
        if (flags !== exp_flags) begin
            errors++;
            $display("FAIL timeout_coincident flags: got %b want %b", flags, exp_flags);
        end
        checks++;
        if (half_period !== 32'd41) begin
            errors++;
            $display("FAIL timeout_coincident half_period: got %0d want 41", half_period);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        lock_up();
        idle(6);
        slow_in = 1'b1;
        cyc();
        slow_in = 1'b0;
        idle(2);
        checks++;
        if (flags !== 5'b10110 || half_period !== 32'd10) begin
            errors++;
            $display("FAIL glitch_rise: flags %b half %0d want flags 10110 half 10", flags, half_period);
        end
        cyc();
        checks++;
        if (flags !== 5'b01100) begin
            errors++;
            $display("FAIL glitch_fall flags: got %b want %b", flags, 5'b01100);
        end
        checks++;
        if (half_period !== 32'd1) begin
            errors++;
            $display("FAIL glitch_fall half_period: got %0d want 1", half_period);
        end
        cyc();
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL glitch_after flags: got %b want %b", flags, 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock_up();
        idle(3);
        rst_n = 1'b0;
        cyc();
        checks++;
        if (flags !== 5'b00000 || half_period !== '0) begin
            errors++;
            $display("FAIL reset_mid: flags %b half %0d want flags 00000 half 0", flags, half_period);
        end
        rst_n = 1'b1;
        idle(2);
        send_edge();
        checks++;
        if (flags !== 5'b10000 || half_period !== '0) begin
            errors++;
            $display("FAIL reset_mid_ref: flags %b half %0d want flags 10000 half 0", flags, half_period);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle(6);
            send_edge();
            exp_flags = {slow_in, ~slow_in, 1'b1, (i == 2), 1'b0};
            checks++;
            if (flags !== exp_flags || half_period !== 32'd10) begin
                errors++;
                $display("FAIL reset_mid_relock[%0d]: flags %b half %0d want flags %b half 10",
                         i, flags, half_period, exp_flags);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
